// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//   Minimal single-outstanding AXI-Lite style master. A one-cycle command
//   (cmd_rd / cmd_wr) starts one transaction. The FSM walks the address, data
//   and response handshakes of the selected direction, then pulses done for
//   one cycle. Any phase that waits TIMEOUT cycles without a handshake is
//   aborted and reported with err=1.
//
// Parameters
//   TIMEOUT        cycles allowed per handshake phase (2..255)
//
// Ports
//   m_clk, rst_n                 clock, asynchronous active-low reset
//   cmd_rd, cmd_wr               one-cycle start requests (read has priority)
//   cmd_addr, cmd_wdata          address / write data, sampled on acceptance
//   rdata                        data of the last successfully completed read
//   busy, done, err              status: in progress / end pulse / timeout flag
//   read_address, AR_VALID, AR_READY, data_read, R_VALID, R_READY
//                                read address and read data channels
//   write_address, AW_VALID, AW_READY, write_data, W_VALID, W_READY,
//   B_VALID, B_READY             write address, write data, write response
//
// All outputs come straight from flops, so they never glitch.
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int TIMEOUT = 16
) (
    input  logic       m_clk,
    input  logic       rst_n,
    input  logic       cmd_rd,
    input  logic       cmd_wr,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] read_address,
    output logic       AR_VALID,
    input  logic       AR_READY,
    input  logic [7:0] data_read,
    input  logic       R_VALID,
    output logic       R_READY,
    output logic [3:0] write_address,
    output logic       AW_VALID,
    input  logic       AW_READY,
    output logic [7:0] write_data,
    output logic       W_VALID,
    input  logic       W_READY,
    input  logic       B_VALID,
    output logic       B_READY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;
    localparam logic [2:0] FINISH  = 3'd6;

    // Last counter value of a phase; a handshake on this cycle still succeeds.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       done_q;
    logic       busy_q;
    logic       ar_valid_q;
    logic       r_ready_q;
    logic       aw_valid_q;
    logic       w_valid_q;
    logic       b_ready_q;
    logic       expired_s;

    assign expired_s = (cnt_q == CNT_LAST);

    // Next-state, latched command fields, captured read data and phase counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_rd) begin
                    state_d = RD_ADDR;
                    addr_d  = cmd_addr;
                end else if (cmd_wr) begin
                    state_d = WR_ADDR;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (ar_valid_q && AR_READY) begin
                    state_d = RD_DATA;
                end else if (expired_s) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_DATA: begin
                if (r_ready_q && R_VALID) begin
                    state_d = FINISH;
                    rdata_d = data_read;
                    err_d   = 1'b0;
                end else if (expired_s) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_ADDR: begin
                if (aw_valid_q && AW_READY) begin
                    state_d = WR_DATA;
                end else if (expired_s) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_DATA: begin
                if (w_valid_q && W_READY) begin
                    state_d = WR_RESP;
                end else if (expired_s) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                if (b_ready_q && B_VALID) begin
                    state_d = FINISH;
                    err_d   = 1'b0;
                end else if (expired_s) begin
                    state_d = FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FINISH: begin
                // Commands seen in this cycle are intentionally dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state change starts the new phase with a fresh counter.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, datapath and status registers; handshake outputs are decoded
    // from the next state so they line up with state_q cycle for cycle.
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 4'd0;
            wdata_q    <= 8'd0;
            rdata_q    <= 8'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            done_q     <= (state_d == FINISH);
            busy_q     <= (state_d != IDLE) && (state_d != FINISH);
            ar_valid_q <= (state_d == RD_ADDR);
            r_ready_q  <= (state_d == RD_DATA);
            aw_valid_q <= (state_d == WR_ADDR);
            w_valid_q  <= (state_d == WR_DATA);
            b_ready_q  <= (state_d == WR_RESP);
        end
    end

    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign read_address  = addr_q;
    assign write_address = addr_q;
    assign write_data    = wdata_q;
    assign AR_VALID      = ar_valid_q;
    assign R_READY       = r_ready_q;
    assign AW_VALID      = aw_valid_q;
    assign W_VALID       = w_valid_q;
    assign B_READY       = b_ready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
//   Directed bench for axi_lite_master. A small combinational slave with
//   per-channel enables and a 16-entry memory answers the master. Expected
//   {err, rdata} pairs are queued when a command is issued; a monitor pops
//   and compares them on every done pulse, and also tracks protocol counters.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

    logic       m_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_rd = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [3:0] cmd_addr = 4'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic [7:0] rdata;
    logic       busy, done, err;
    logic [3:0] read_address, write_address;
    logic [7:0] data_read, write_data;
    logic       AR_VALID, AR_READY, R_VALID, R_READY;
    logic       AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    // slave controls
    logic       ar_en = 1'b1;
    logic       r_en  = 1'b1;
    logic       aw_en = 1'b1;
    logic       w_en  = 1'b1;
    logic       b_en  = 1'b1;
    logic       pre_en = 1'b0;
    logic [3:0] pre_a = 4'd0;
    logic [7:0] pre_d = 8'd0;
    logic [7:0] mem [16];

    // scoreboard / counters
    logic [8:0] exp_q [$];
    string      name_q [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         ar_cnt = 0;
    int         aw_cnt = 0;
    int         onehot_viol = 0;
    int         order_viol = 0;
    logic       aw_seen = 1'b0;

    always #5 m_clk = ~m_clk;

    axi_lite_master #(.TIMEOUT(16)) dut (
        .m_clk(m_clk), .rst_n(rst_n),
        .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rdata(rdata), .busy(busy), .done(done), .err(err),
        .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .data_read(data_read), .R_VALID(R_VALID), .R_READY(R_READY),
        .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .write_data(write_data), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY)
    );

    assign AR_READY  = ar_en;
    assign R_VALID   = r_en;
    assign data_read = mem[read_address];
    assign AW_READY  = aw_en;
    assign W_READY   = w_en;
    assign B_VALID   = b_en;

    // slave memory: preload port or accepted write beat
    always @(posedge m_clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (W_VALID && W_READY) mem[write_address] <= write_data;
    end

    // monitor: scoreboard on done, protocol counters every cycle
    always @(negedge m_clk) begin
        logic [8:0] exp_v;
        string      nm;
        int         nv;
        nv = int'(AR_VALID) + int'(AW_VALID) + int'(W_VALID) + int'(R_READY) + int'(B_READY);
        if (nv > 1) onehot_viol = onehot_viol + 1;
        if (AR_VALID) ar_cnt = ar_cnt + 1;
        if (AW_VALID) aw_cnt = aw_cnt + 1;
        if (W_VALID && !aw_seen) order_viol = order_viol + 1;
        if (AW_VALID && AW_READY) aw_seen = 1'b1;
        if (!rst_n) aw_seen = 1'b0;
        if (done) begin
            done_cnt = done_cnt + 1;
            aw_seen = 1'b0;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: got err=%0b rdata=%02h, expected no done", err, rdata);
            end else begin
                exp_v = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({err, rdata} !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL %s: got err=%0b rdata=%02h, expected err=%0b rdata=%02h",
                             nm, err, rdata, exp_v[8], exp_v[7:0]);
                end
            end
            checks = checks + 1;
            if (busy !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL busy_at_done: got %0b, expected 0", busy);
            end
        end
    end

    task automatic check_int(input string nm, input int got, input int expv);
        checks = checks + 1;
        if (got != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] a,
                         input logic [7:0] d, input logic push,
                         input logic e_err, input logic [7:0] e_rdata, input string nm);
        @(negedge m_clk);
        if (push) begin
            exp_q.push_back({e_err, e_rdata});
            name_q.push_back(nm);
        end
        cmd_rd = rd; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge m_clk);
        #1;
        cmd_rd = 1'b0; cmd_wr = 1'b0;
    endtask

    task automatic wait_done(input int target, input string nm);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge m_clk);
            n = n + 1;
        end
        if (done_cnt < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got done_cnt=%0d, expected %0d", nm, done_cnt, target);
        end
        repeat (3) @(posedge m_clk);
    endtask

    // bounded wait until a DUT output bit is high (sampled after negedge)
    task automatic wait_high(input int sel, input string nm);
        int n;
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < 100) begin
            @(negedge m_clk);
            #1;
            case (sel)
                0: v = W_VALID;
                1: v = R_READY;
                default: v = done;
            endcase
            n = n + 1;
        end
        checks = checks + 1;
        if (!v) begin
            errors = errors + 1;
            $display("FAIL %s: got 0 after %0d cycles, expected 1", nm, n);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {rdata, busy, done, err, read_address, AR_VALID, R_READY,
                write_address, AW_VALID, write_data, W_VALID, B_READY};
    endfunction

    initial begin
        int base_ar, base_aw, base_done, n;
        // reset state
        #1 rst_n = 1'b0;
        #2;
        checks = checks + 1;
        if (out_vec() !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: got %08h, expected 00000000", out_vec());
        end
        repeat (2) @(negedge m_clk);
        rst_n = 1'b1;

        // preload slave memory
        @(negedge m_clk);
        pre_en = 1'b1; pre_a = 4'h5; pre_d = 8'h55;
        @(negedge m_clk);
        pre_en = 1'b0;

        // basic read
        issue(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 8'h55, "read_5");
        wait_done(1, "read_5");

        // write then read back
        issue(1'b0, 1'b1, 4'hA, 8'h3C, 1'b1, 1'b0, 8'h55, "write_A");
        wait_done(2, "write_A");
        issue(1'b1, 1'b0, 4'hA, 8'h00, 1'b1, 1'b0, 8'h3C, "read_A");
        wait_done(3, "read_A");

        // simultaneous read and write: read wins
        base_aw = aw_cnt;
        issue(1'b1, 1'b1, 4'h5, 8'h99, 1'b1, 1'b0, 8'h55, "rd_wr_same");
        wait_done(4, "rd_wr_same");
        check_int("rd_wr_same_aw_cycles", aw_cnt - base_aw, 0);
        check_int("rd_wr_same_dones", done_cnt, 4);

        // read address timeout
        ar_en = 1'b0;
        base_ar = ar_cnt;
        issue(1'b1, 1'b0, 4'hA, 8'h00, 1'b1, 1'b1, 8'h55, "ar_timeout");
        wait_done(5, "ar_timeout");
        check_int("ar_timeout_valid_cycles", ar_cnt - base_ar, 16);

        // handshake on the last counter value still succeeds
        base_ar = ar_cnt;
        issue(1'b1, 1'b0, 4'hA, 8'h00, 1'b1, 1'b0, 8'h3C, "ar_last_cycle");
        n = 0;
        while ((ar_cnt - base_ar) < 16 && n < 40) begin
            @(negedge m_clk);
            #1;
            n = n + 1;
        end
        ar_en = 1'b1;
        wait_done(6, "ar_last_cycle");
        check_int("ar_last_cycle_valid_cycles", ar_cnt - base_ar, 16);

        // write response timeout
        b_en = 1'b0;
        issue(1'b0, 1'b1, 4'h3, 8'h77, 1'b1, 1'b1, 8'h3C, "b_timeout");
        wait_done(7, "b_timeout");
        b_en = 1'b1;

        // command during busy and during FINISH is ignored
        r_en = 1'b0;
        base_aw = aw_cnt;
        issue(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 8'h55, "busy_cmd");
        wait_high(1, "busy_cmd_r_ready");
        cmd_wr = 1'b1; cmd_addr = 4'h2; cmd_wdata = 8'h11;
        @(posedge m_clk);
        #1 cmd_wr = 1'b0;
        r_en = 1'b1;
        wait_high(2, "busy_cmd_done");
        cmd_wr = 1'b1;
        @(posedge m_clk);
        #1 cmd_wr = 1'b0;
        repeat (6) @(posedge m_clk);
        check_int("busy_cmd_aw_cycles", aw_cnt - base_aw, 0);
        check_int("busy_cmd_dones", done_cnt, 8);

        // reset in the middle of a write data phase
        w_en = 1'b0;
        base_done = done_cnt;
        issue(1'b0, 1'b1, 4'h7, 8'hEE, 1'b0, 1'b0, 8'h00, "");
        wait_high(0, "mid_write_w_valid");
        #2 rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (out_vec() !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL mid_write_reset_outputs: got %08h, expected 00000000", out_vec());
        end
        repeat (2) @(negedge m_clk);
        rst_n = 1'b1;
        w_en = 1'b1;
        repeat (3) @(posedge m_clk);
        check_int("mid_write_no_done", done_cnt - base_done, 0);
        issue(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 1'b0, 8'h55, "read_after_reset");
        wait_done(base_done + 1, "read_after_reset");

        // global protocol properties
        check_int("scoreboard_empty", exp_q.size(), 0);
        check_int("onehot_violations", onehot_viol, 0);
        check_int("w_before_aw_violations", order_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, max cycles waited in any single handshake phase before abort (legal range 2..255).
REQ-002 SHALL have port: m_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_rd  input  1  one-cycle request to start a read.
REQ-005 SHALL have port: cmd_wr  input  1  one-cycle request to start a write.
REQ-006 SHALL have port: cmd_addr  input  4  target address, sampled with the accepted command.
REQ-007 SHALL have port: cmd_wdata  input  8  write data, sampled with an accepted cmd_wr.
REQ-008 SHALL have port: rdata  output  8  last read data, held until the next completed read.
REQ-009 SHALL have port: busy  output  1  high from command acceptance until done.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at end of every transaction.
REQ-011 SHALL have port: err  output  1  valid with done; 1 = timeout abort.
REQ-012 SHALL have ports: read_address out 4, AR_VALID out 1, AR_READY in 1; data_read in 8, R_VALID in 1, R_READY out 1.
REQ-013 SHALL have ports: write_address out 4, AW_VALID out 1, AW_READY in 1; write_data out 8, W_VALID out 1, W_READY in 1; B_VALID in 1, B_READY out 1.

Function
REQ-014 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, FINISH.
REQ-015 IDLE: cmd_rd=1 -> RD_ADDR; else cmd_wr=1 -> WR_ADDR; both high same cycle -> read wins, write dropped.
REQ-016 Commands arriving while busy=1 SHALL be ignored with no queuing.
REQ-017 Acceptance SHALL latch cmd_addr (and cmd_wdata for writes) into internal registers; address/data outputs driven only from those registers.
REQ-018 Handshake on any channel SHALL complete at a rising edge where VALID and READY are both 1.
REQ-019 RD_ADDR: AR_VALID=1, read_address=latched addr, held stable until AR handshake; then AR_VALID=0 next cycle and -> RD_DATA.
REQ-020 RD_DATA: R_READY=1; on R_VALID=1 capture data_read into rdata, R_READY=0 next cycle, -> FINISH with err=0.
REQ-021 WR_ADDR: AW_VALID=1 with write_address held until AW handshake, -> WR_DATA; W_VALID SHALL NOT rise before AW handshake completes.
REQ-022 WR_DATA: W_VALID=1, write_data=latched data until W handshake, -> WR_RESP.
REQ-023 WR_RESP: B_READY=1; on B_VALID=1 -> FINISH with err=0.
REQ-024 FINISH: done=1, busy=0 for exactly one cycle, -> IDLE; a command in the FINISH cycle SHALL be ignored.
REQ-025 An 8-bit phase counter SHALL clear on every state entry and increment each cycle in RD_ADDR/RD_DATA/WR_ADDR/WR_DATA/WR_RESP.
REQ-026 Counter reaching TIMEOUT-1 without handshake SHALL deassert all VALID/READY outputs next cycle and -> FINISH with err=1; rdata unchanged.
REQ-027 A handshake in the same cycle as counter=TIMEOUT-1 SHALL count as success (err=0).
REQ-028 At most one of AR_VALID, AW_VALID, W_VALID, R_READY, B_READY SHALL be 1 in any cycle.
REQ-029 err SHALL hold its value until next done; busy SHALL be 1 in every non-IDLE, non-FINISH state.

Reset
REQ-030 rst_n=0 SHALL immediately, without clock, force state IDLE, counter 0, rdata 8'h00, busy/done/err 0, all VALID/READY outputs 0, address/data outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it with no done pulse; first command after rst_n rises SHALL be accepted normally.

Verification
REQ-032 Read: cmd_rd, addr 4'h5, slave preloaded 8'h55 -> AR then R handshake, rdata=8'h55, done=1 err=0, busy low after FINISH.
REQ-033 Write-then-read: cmd_wr addr 4'hA data 8'h3C, then cmd_rd addr 4'hA -> AW before W, B accepted, rdata=8'h3C, both err=0.
REQ-034 Simultaneous cmd_rd and cmd_wr in IDLE -> only read runs; no AW_VALID ever asserted; one done pulse.
REQ-035 Timeout: AR_READY tied 0, TIMEOUT=16 -> AR_VALID high exactly 16 cycles, then done=1 err=1, rdata unchanged.
REQ-036 Reset mid-write: rst_n low while W_VALID=1 -> all outputs 0 asynchronously, no done; subsequent read completes correctly.
REQ-037 Command during busy: cmd_wr pulsed during RD_DATA -> ignored, exactly one done, no AW_VALID.
